// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared constants for the SR latch bank.
//   MODE_*      : encoding of the action taken when S and R are both high.
//   mode_valid  : elaboration-time helper to reject out-of-range modes.
package sr_bank_pkg;

  localparam int unsigned MODE_HOLD   = 0;  // keep q
  localparam int unsigned MODE_SET    = 1;  // set-dominant
  localparam int unsigned MODE_RST    = 2;  // reset-dominant
  localparam int unsigned MODE_TOGGLE = 3;  // invert q

  function automatic bit mode_valid(input int unsigned mode);
    return mode <= MODE_TOGGLE;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// sr_cell: one SR channel. Holds the q register and the sticky conflict flag.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   s, r           : set / reset request for this channel
//   en             : update enable for q (conflict detection ignores it)
//   clr_err        : synchronous clear of the sticky flag; wins over a new conflict
//   q              : registered channel state
//   conflict_flag  : sticky S=R=1 indicator
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int unsigned MODE = MODE_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic en,
  input  logic clr_err,
  output logic q,
  output logic conflict_flag
);

  logic q_nxt;
  logic conflict;

  assign conflict = s & r;

  always_comb begin
    q_nxt = q;
    if (en) begin
      unique case ({s, r})
        2'b10:   q_nxt = 1'b1;
        2'b01:   q_nxt = 1'b0;
        2'b11: begin
          // MODE is a parameter, so only one arm survives elaboration.
          if (MODE == MODE_SET)         q_nxt = 1'b1;
          else if (MODE == MODE_RST)    q_nxt = 1'b0;
          else if (MODE == MODE_TOGGLE) q_nxt = ~q;
          else                          q_nxt = q;
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q             <= 1'b0;
      conflict_flag <= 1'b0;
    end else begin
      q <= q_nxt;
      if (clr_err)       conflict_flag <= 1'b0;
      else if (conflict) conflict_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/param_sr_bank.sv
// param_sr_bank: bank of CH independent SR channels with conflict monitoring.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   s, r [CH]      : per-channel set / reset requests
//   en             : global enable for q updates
//   clr_err        : synchronous clear of conflict_flag / conflict_cnt
//   q, qn [CH]     : registered state and its complement
//   conflict_flag  : sticky per-channel S=R=1 flags
//   conflict_cnt   : saturating count of cycles with at least one conflict
//   irq            : registered OR of conflict_flag
module param_sr_bank
  import sr_bank_pkg::*;
#(
  parameter int unsigned CH            = 8,
  parameter int unsigned CONFLICT_MODE = 2'd0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             en,
  input  logic             clr_err,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qn,
  output logic [CH-1:0]    conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             irq
);

  if (!mode_valid(CONFLICT_MODE)) begin : g_bad_mode
    $error("param_sr_bank: CONFLICT_MODE %0d out of range 0..3", CONFLICT_MODE);
  end
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("param_sr_bank: CH %0d out of range 1..32", CH);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic conflict_any;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    sr_cell #(.MODE(CONFLICT_MODE)) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .s             (s[i]),
      .r             (r[i]),
      .en            (en),
      .clr_err       (clr_err),
      .q             (q[i]),
      .conflict_flag (conflict_flag[i])
    );
  end

  // Derived from the q register only, so qn is never X after reset and
  // has no path from s/r.
  assign qn = ~q;

  // One count per cycle regardless of how many channels conflict.
  assign conflict_any = |(s & r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      irq          <= 1'b0;
    end else begin
      if (clr_err)                                    conflict_cnt <= '0;
      else if (conflict_any && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
      // Sampled from the flag register, so irq trails the flag by one edge.
      irq <= |conflict_flag;
    end
  end

endmodule

// File: tb/tb_param_sr_bank.sv
// Four DUTs (one per conflict mode) share the same stimulus. A queue-based
// scoreboard holds the expected post-edge state from a behavioural model;
// a monitor pops and compares one entry per clock edge (or per async
// reset pulse).
module tb_param_sr_bank;

  localparam int NM = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           s = '0, r = '0;
  logic                 en = 1'b0, clr_err = 1'b0;
  logic [NM-1:0][7:0]   dq, dqn, dfl;
  logic [NM-1:0][3:0]   dcnt;
  logic [NM-1:0]        dirq;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    param_sr_bank #(.CH(8), .CONFLICT_MODE(g), .CNT_W(4)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s             (s),
      .r             (r),
      .en            (en),
      .clr_err       (clr_err),
      .q             (dq[g]),
      .qn            (dqn[g]),
      .conflict_flag (dfl[g]),
      .conflict_cnt  (dcnt[g]),
      .irq           (dirq[g])
    );
  end

  typedef struct {
    logic [NM-1:0][7:0] q;
    logic [NM-1:0][7:0] fl;
    logic [NM-1:0][3:0] cnt;
    logic [NM-1:0]      irq;
    string              tag;
  } exp_t;

  exp_t exp_q[$];
  event async_chk;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state
  logic [7:0] mq [NM];
  logic [7:0] mfl[NM];
  int         mcnt[NM];
  logic       mirq[NM];

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      mq[m] = '0; mfl[m] = '0; mcnt[m] = 0; mirq[m] = 1'b0;
    end
  endtask

  task automatic model_step(input logic rst_i, input logic [7:0] s_i, r_i,
                            input logic en_i, clr_i);
    if (!rst_i) begin
      model_reset();
      return;
    end
    for (int m = 0; m < NM; m++) begin
      logic nirq;
      nirq = (mfl[m] != 0);
      if (en_i) begin
        for (int b = 0; b < 8; b++) begin
          if (s_i[b] && !r_i[b])      mq[m][b] = 1'b1;
          else if (!s_i[b] && r_i[b]) mq[m][b] = 1'b0;
          else if (s_i[b] && r_i[b]) begin
            case (m)
              1: mq[m][b] = 1'b1;
              2: mq[m][b] = 1'b0;
              3: mq[m][b] = ~mq[m][b];
              default: ;
            endcase
          end
        end
      end
      if (clr_i) begin
        mfl[m] = '0; mcnt[m] = 0;
      end else begin
        mfl[m] = mfl[m] | (s_i & r_i);
        if ((s_i & r_i) != 0 && mcnt[m] < 15) mcnt[m]++;
      end
      mirq[m] = nirq;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    for (int m = 0; m < NM; m++) begin
      e.q[m] = mq[m]; e.fl[m] = mfl[m]; e.cnt[m] = 4'(mcnt[m]); e.irq[m] = mirq[m];
    end
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, enqueue.
  task automatic cyc(input string tag, input logic [7:0] s_i, r_i,
                     input logic en_i, clr_i, input logic rst_i = 1'b1);
    @(negedge clk);
    s = s_i; r = r_i; en = en_i; clr_err = clr_i; rst_n = rst_i;
    model_step(rst_i, s_i, r_i, en_i, clr_i);
    push_exp(tag);
  endtask

  // Reset pulse strictly between edges; checked before the next edge.
  task automatic async_pulse(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    push_exp(tag);
    -> async_chk;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input string tag, input int m,
                     input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s mode%0d [%s] t=%0t got %h want %h", nm, m, tag, $time, act, exp_v);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int m = 0; m < NM; m++) begin
          chk("q",    e.tag, m, dq[m],   e.q[m]);
          chk("qn",   e.tag, m, dqn[m],  ~e.q[m]);
          chk("flag", e.tag, m, dfl[m],  e.fl[m]);
          chk("cnt",  e.tag, m, {4'h0, dcnt[m]}, {4'h0, e.cnt[m]});
          chk("irq",  e.tag, m, {7'h0, dirq[m]}, {7'h0, e.irq[m]});
        end
      end
    end
  end

  // Stimulus
  initial begin
    model_reset();
    cyc("reset0", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc("reset1", 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0);

    // First edge after release: plain set
    cyc("set0F",  8'h0F, 8'h00, 1'b1, 1'b0);
    cyc("hold",   8'h00, 8'h00, 1'b1, 1'b0);
    cyc("rst03",  8'h00, 8'h03, 1'b1, 1'b0);

    // Conflict on ch0 with q[0]=1, three edges
    cyc("setch0", 8'h01, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("conf0", 8'h01, 8'h01, 1'b1, 1'b0);
    cyc("irqlag", 8'h00, 8'h00, 1'b1, 1'b0);

    // Clear, zero q, then all-channel conflict
    cyc("clr",    8'h00, 8'hFF, 1'b1, 1'b1);
    cyc("allcf",  8'hFF, 8'hFF, 1'b1, 1'b0);
    cyc("idle",   8'h00, 8'h00, 1'b1, 1'b0);

    // Enable low: q frozen, conflict still detected
    cyc("clr2",   8'h00, 8'h00, 1'b1, 1'b1);
    cyc("en0set", 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc("en0cf2", 8'h04, 8'h04, 1'b0, 1'b0);
    cyc("en0idl", 8'h00, 8'h00, 1'b0, 1'b0);

    // Saturation on ch5, then clear with a concurrent conflict
    for (int i = 0; i < 20; i++) cyc("sat5", 8'h20, 8'h20, 1'b1, 1'b0);
    cyc("clrcf",  8'h20, 8'h20, 1'b1, 1'b1);
    cyc("post",   8'h00, 8'h00, 1'b1, 1'b0);
    cyc("post2",  8'h00, 8'h00, 1'b1, 1'b0);

    // Async reset between edges while q=AA with error state set
    cyc("ldAA",   8'hAA, 8'h55, 1'b1, 1'b0);
    cyc("cfAA",   8'h02, 8'h02, 1'b1, 1'b0);
    async_pulse("areset");
    cyc("after",  8'h00, 8'h00, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] sv, rv;
      sv = 8'($urandom);
      rv = 8'($urandom) & 8'($urandom);
      cyc("rand", sv, rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 39) == 0) async_pulse("rand_ar");
    end

    cyc("tail", 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_sr_bank.md
PARAM_SR_BANK -- requirements
Module: param_sr_bank

Interface
REQ-001 Parameter CH, default 8: number of independent SR channels, range 1..32.
REQ-002 Parameter CONFLICT_MODE, default 2'd0: action when S=R=1 (0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle).
REQ-003 Parameter CNT_W, default 8: width of the conflict event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s  input  CH  per-channel set request, sampled on clk.
REQ-007 r  input  CH  per-channel reset request, sampled on clk.
REQ-008 en  input  1  global update enable; 0 freezes q.
REQ-009 clr_err  input  1  synchronous clear of conflict_flag and conflict_cnt.
REQ-010 q  output  CH  registered channel state.
REQ-011 qn  output  CH  always bitwise complement of q; never X, never equal to q.
REQ-012 conflict_flag  output  CH  sticky per-channel S=R=1 detection.
REQ-013 conflict_cnt  output  CNT_W  saturating count of cycles with any conflict.
REQ-014 irq  output  1  registered OR of conflict_flag.

Function
REQ-015 With en=1, per channel at the clock edge: s=0,r=0 -> hold; s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=1,r=1 -> per CONFLICT_MODE.
REQ-016 Conflict actions: hold -> q unchanged; set-dominant -> q=1; reset-dominant -> q=0; toggle -> q=~q.
REQ-017 With en=0, q holds regardless of s/r; conflict detection still operates.
REQ-018 Latency: q reflects s/r one cycle after the sampling edge; combinational paths from s/r to q/qn are forbidden.
REQ-019 conflict_flag[i] sets on the edge where s[i]=r[i]=1 and remains set until clr_err or reset.
REQ-020 conflict_cnt increments by 1 per cycle in which any channel has s=r=1 (not per channel); saturates at 2^CNT_W-1 without wrap.
REQ-021 clr_err=1 with a simultaneous conflict: clear wins for that cycle; the conflict is neither flagged nor counted.
REQ-022 irq is the OR of the conflict_flag register, registered; it asserts one cycle after the flag and deasserts one cycle after clear.
REQ-023 Channels are fully independent; activity on one channel never alters q of another.
REQ-024 CONFLICT_MODE outside 0..3 is a elaboration-time error.

Reset
REQ-025 rst_n low asynchronously forces q=0, qn=all ones, conflict_flag=0, conflict_cnt=0, irq=0.
REQ-026 Reset asserted mid-operation (including during a conflict) overrides all inputs immediately; no event is recorded.
REQ-027 Deassertion is synchronised externally; the first active edge after release applies normal rules.

Structure
REQ-028 Package sr_bank_pkg holds the CONFLICT_MODE encoding constants (MODE_HOLD, MODE_SET, MODE_RST, MODE_TOGGLE).
REQ-029 One sub-module sr_cell (single channel: q register, conflict detect, sticky flag) is instantiated CH times; counter and irq logic stay at top level.

Verification
REQ-030 Reset then s=8'h0F,r=0,en=1 for one edge -> q=8'h0F, qn=8'hF0 next cycle; conflict_cnt=0.
REQ-031 CONFLICT_MODE=3, q[0]=1, s[0]=r[0]=1 for 3 edges -> q[0] sequence 0,1,0; conflict_flag[0]=1; conflict_cnt=3; irq=1 one cycle after flag.
REQ-032 CONFLICT_MODE=1 and 2 each with q=0, s=r=8'hFF -> q=8'hFF (set-dom) / 8'h00 (reset-dom); conflict_flag=8'hFF.
REQ-033 CNT_W=4, continuous conflict on channel 5 for 20 cycles -> conflict_cnt stops at 15; clr_err with a concurrent conflict -> cnt=0, flag=0.
REQ-034 en=0 with s=8'hFF -> q unchanged; s=r=1 on channel 2 still sets conflict_flag[2].
REQ-035 rst_n pulsed low between edges while q=8'hAA -> q=0 immediately, before the next clk edge; all error state cleared.
